fxp_div_arbiter: RTL and testbench
==================================

# fxp_div_arbiter

Sequencer and two-port round-robin arbiter for the shared 8-bit fixed-point long-division unit. Two requesters submit dividend/divisor pairs over valid/ready handshakes. The block grants one of them, launches the divider with a one-cycle start pulse and waits for its done pulse. It then holds the quotient on a per-requester response handshake until that requester accepts it. Divide-by-zero is resolved locally without occupying the divider, and a watchdog covers a divider that never signals done.

## Interface
- `W`, default 8: operand and quotient width.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before the divider is declared hung.
- `TW`, default 7: watchdog counter width; must satisfy 2^TW > TIMEOUT.
- One clock `clk`; reset `reset` is synchronous and active-high.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester request accept.
- `req_dividend`  in  2*W  `[W-1:0]` is requester 0, `[2W-1:W]` is requester 1.
- `req_divisor`  in  2*W  packed the same way as `req_dividend`.
- `div_start`  out  1  one-cycle launch pulse to the divider.
- `div_dividend`  out  W  registered operand to the divider.
- `div_divisor`  out  W  registered operand to the divider.
- `div_done`  in  1  one-cycle completion pulse from the divider.
- `div_quotient`  in  W  divider result, valid when `div_done` is high.
- `rsp_valid`  out  2  per-requester response valid.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_quotient`  out  W  result, shared by both response ports.
- `rsp_dz`  out  1  divide-by-zero flag for the current response.
- `rsp_timeout`  out  1  watchdog-expiry flag for the current response.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The grant index `g` and the last-grant register `last` are both 1 bit.
- **IDLE**
  - If exactly one `req_valid` bit is set, grant that requester.
  - If both are set, grant `~last`.
  - `req_ready[g]` is asserted combinationally only in IDLE and only for the granted index; all other `req_ready` bits are 0.
  - On the handshake, latch that requester's operands into `div_dividend`/`div_divisor` and latch `g`.
  - If the latched divisor is 0: go to RESP with `rsp_quotient = {W{1'b1}}`, `rsp_dz = 1`.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `div_start = 1` for exactly this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - The watchdog counter increments each cycle.
  - On `div_done`: capture `div_quotient` into `rsp_quotient`, clear both flags, go to RESP.
  - If the counter reaches `TIMEOUT` without `div_done`: set `rsp_quotient = 0`, `rsp_timeout = 1`, go to RESP.
  - If `div_done` arrives in the expiry cycle, `div_done` wins.
- **RESP**
  - `rsp_valid[g] = 1`; the other bit is 0.
  - `rsp_quotient`, `rsp_dz` and `rsp_timeout` stay stable until the handshake.
  - On `rsp_ready[g]`: set `last = g`, clear the flags, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- A `div_done` outside WAIT is ignored and nothing is captured.
- `req_valid` of the non-granted requester may stay high indefinitely; it is served on the next IDLE visit.
- Operands pass through unmodified; the fixed-point format is owned by the divider.

## Timing
- Reset values:
  - State: IDLE.
  - `last = 1`, so requester 0 wins the first tie.
  - Zero: `req_ready`, `div_start`, `div_dividend`, `div_divisor`, `rsp_valid`, `rsp_quotient`, `rsp_dz`, `rsp_timeout`, `busy`, and the watchdog counter.
- Reset at any point, including WAIT or RESP:
  - Return to IDLE next cycle and drop any pending result.
  - A late `div_done` after reset is ignored.
- Normal division, request accepted in cycle T and divider latency L (start to done):
  - `div_start` in cycle T+1.
  - `div_done` in cycle T+1+L.
  - `rsp_valid` first high in cycle T+2+L.
- Divide-by-zero: `rsp_valid` in cycle T+1; `div_start` never pulses.
- Timeout: `rsp_valid` in cycle T+2+TIMEOUT.
- Throughput: at most one operation in flight; the next `req_ready` can assert in the cycle after the response handshake.
- `rsp_valid` may be held arbitrarily long; the arbiter stalls in RESP.

## Test plan
- **Single request, normal division.** Req0 sends 100/5; divider model has L=8 and returns 20. Required: `div_start` in T+1, `rsp_valid[0]` in T+10 with `rsp_quotient = 20`, `rsp_dz = 0`.
- **Tie and alternation.** Both requesters valid at the same time, back-to-back for 4 operations. Required: grant order 0,1,0,1; each result appears only on its own `rsp_valid` bit.
- **Divide by zero.** Req1 sends 37/0. Required: no `div_start`; `rsp_valid[1]` in T+1 with `rsp_quotient = 8'hFF`, `rsp_dz = 1`.
- **Hung divider.** Divider never returns done, `TIMEOUT = 64`. Required: `rsp_valid` with `rsp_timeout = 1` and `rsp_quotient = 0`, 66 cycles after the request handshake. A subsequent request completes normally.
- **Response backpressure.** `rsp_ready` held low for 20 cycles while req1 is valid. Required: response data stable throughout, `req_ready = 0` and `busy = 1` throughout; req1 is accepted the cycle after the response handshake.
- **Reset mid-operation.** `reset` asserted in WAIT, then a stray `div_done` arrives. Required: all outputs at reset values next cycle, state IDLE, the stray `div_done` produces no `rsp_valid`, and `last = 1`.

Source files
------------

// File: rtl/fxp_div_arbiter.sv
// Two-port round-robin front end for a shared fixed-point long divider:
// grants one requester, runs the divider (or short-circuits /0), holds the result until accepted.
module fxp_div_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_dividend,
  input  logic [2*W-1:0] req_divisor,
  output logic           div_start,
  output logic [W-1:0]   div_dividend,
  output logic [W-1:0]   div_divisor,
  input  logic           div_done,
  input  logic [W-1:0]   div_quotient,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_quotient,
  output logic           rsp_dz,
  output logic           rsp_timeout,
  output logic           busy,
  output logic [1:0]     dbg_state,
  output logic           dbg_last
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // valid never waits on ready, and request ready is only offered in IDLE to the granted port.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_g;
  logic          r_last;
  logic [TW-1:0] r_cnt;

  logic          w_grant;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_expire;
  logic [W-1:0]  w_sel_dividend;
  logic [W-1:0]  w_sel_divisor;

  // On a tie the requester that did not win last time gets the grant.
  assign w_grant        = (&req_valid) ? ~r_last : req_valid[1];
  assign w_sel_dividend = w_grant ? req_dividend[2*W-1:W] : req_dividend[W-1:0];
  assign w_sel_divisor  = w_grant ? req_divisor[2*W-1:W]  : req_divisor[W-1:0];
  assign w_req_fire     = (r_state == S_IDLE) && req_valid[w_grant];
  assign w_rsp_fire     = (r_state == S_RESP) && rsp_ready[r_g];
  assign w_expire       = (r_cnt == TW'(TIMEOUT - 1));

  assign dbg_state = r_state;
  assign dbg_last  = r_last;

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    div_start = 1'b0;
    rsp_valid = 2'b00;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          req_ready[w_grant] = 1'b1;
          w_next = (w_sel_divisor == '0) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (div_done || w_expire) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_g] = 1'b1;
        if (w_rsp_fire) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_g          <= 1'b0;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rsp_quotient <= '0;
      rsp_dz       <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_g          <= w_grant;
            div_dividend <= w_sel_dividend;
            div_divisor  <= w_sel_divisor;
            if (w_sel_divisor == '0) begin
              rsp_quotient <= '1;
              rsp_dz       <= 1'b1;
            end
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          // A done in the expiry cycle still delivers the real quotient.
          if (div_done) begin
            rsp_quotient <= div_quotient;
            rsp_dz       <= 1'b0;
            rsp_timeout  <= 1'b0;
          end else if (w_expire) begin
            rsp_quotient <= '0;
            rsp_timeout  <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_fire) begin
            r_last      <= r_g;
            rsp_dz      <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div_arbiter.sv
// Directed bench for fxp_div_arbiter: driver tasks push expected responses,
// a negedge monitor pops and checks them against what the arbiter presents.
module tb_fxp_div_arbiter;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;
  localparam int L       = 8;
  localparam int EW      = 1 + W + 1 + 1 + 8;

  logic           clk;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_dividend;
  logic [2*W-1:0] req_divisor;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_done;
  logic [W-1:0]   div_quotient;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_quotient;
  logic           rsp_dz;
  logic           rsp_timeout;
  logic           busy;
  logic [1:0]     dbg_state;
  logic           dbg_last;

  logic model_done;
  logic stray_done;
  assign div_done = model_done | stray_done;

  fxp_div_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_dz(rsp_dz), .rsp_timeout(rsp_timeout),
    .busy(busy), .dbg_state(dbg_state), .dbg_last(dbg_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input logic p, input logic [W-1:0] q, input logic dz,
                      input logic to, input logic [7:0] lat);
    exp_q.push_back({p, q, dz, to, lat});
  endtask

  // ---------------- divider model (latency L, optional hang) ----------------
  logic hang = 1'b0;
  logic pend = 1'b0;
  int   dl   = 0;
  logic [W-1:0] ma, mb;
  initial begin
    model_done   = 1'b0;
    div_quotient = '0;
  end
  always @(posedge clk) begin
    #2;
    model_done = 1'b0;
    if (!busy) pend = 1'b0;
    else if (pend) begin
      dl = dl - 1;
      if (dl == 0) begin
        pend = 1'b0;
        if (!hang) begin
          model_done   = 1'b1;
          div_quotient = ma / mb;
        end
      end
    end
    if (div_start) begin
      pend = 1'b1;
      dl   = L;
      ma   = div_dividend;
      mb   = div_divisor;
    end
  end

  // ---------------- monitor ----------------
  int            t_acc = 0;
  logic          in_resp = 1'b0;
  logic [EW-1:0] cur;
  always @(negedge clk) begin
    if (reset) in_resp = 1'b0;
    else begin
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && req_ready[p]) t_acc = cyc;
      if (div_start) begin
        n_start++;
        chk("start_latency", cyc - t_acc, 1);
      end
      if (!in_resp && rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {30'd0, rsp_valid}, 0);
        else begin
          cur = exp_q.pop_front();
          chk("rsp_latency", cyc - t_acc, {24'd0, cur[7:0]});
          in_resp = 1'b1;
        end
      end
      if (in_resp) begin
        chk("rsp_port",    {30'd0, rsp_valid}, cur[EW-1] ? 2 : 1);
        chk("rsp_quotient", {24'd0, rsp_quotient}, {24'd0, cur[17:10]});
        chk("rsp_dz",      {31'd0, rsp_dz}, {31'd0, cur[9]});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, cur[8]});
        chk("resp_busy",   {31'd0, busy}, 1);
        chk("resp_req_ready", {30'd0, req_ready}, 0);
        if ((rsp_valid & rsp_ready) != 2'b00) in_resp = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[p] = 1'b1;
    req_dividend[p*W +: W] = a;
    req_divisor[p*W +: W]  = b;
  endtask

  task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 1'b0;
    @(posedge clk); #1;
    set_req(p, a, b);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_ready[p]) got = 1'b1;
    end
    if (!got) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready",    {30'd0, req_ready}, 0);
    chk("rst_div_start",    {31'd0, div_start}, 0);
    chk("rst_div_dividend", {24'd0, div_dividend}, 0);
    chk("rst_div_divisor",  {24'd0, div_divisor}, 0);
    chk("rst_rsp_valid",    {30'd0, rsp_valid}, 0);
    chk("rst_rsp_quotient", {24'd0, rsp_quotient}, 0);
    chk("rst_rsp_dz",       {31'd0, rsp_dz}, 0);
    chk("rst_rsp_timeout",  {31'd0, rsp_timeout}, 0);
    chk("rst_busy",         {31'd0, busy}, 0);
    chk("rst_state",        {30'd0, dbg_state}, 0);
    chk("rst_last",         {31'd0, dbg_last}, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  k0, k1, guard, n0;
    bit  h0, h1, seen;
    reset        = 1'b1;
    req_valid    = 2'b00;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 2'b11;
    stray_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // Tie and alternation: 60/3=20, 77/7=11, 90/9=10, 200/8=25 in grant order 0,1,0,1.
    push(1'b0, 8'd20, 1'b0, 1'b0, 8'd10);
    push(1'b1, 8'd11, 1'b0, 1'b0, 8'd10);
    push(1'b0, 8'd10, 1'b0, 1'b0, 8'd10);
    push(1'b1, 8'd25, 1'b0, 1'b0, 8'd10);
    @(posedge clk); #1;
    set_req(0, 8'd60, 8'd3);
    set_req(1, 8'd77, 8'd7);
    k0 = 0; k1 = 0; guard = 0;
    while ((k0 < 2 || k1 < 2) && guard < 300) begin
      @(negedge clk);
      h0 = req_valid[0] && req_ready[0];
      h1 = req_valid[1] && req_ready[1];
      @(posedge clk); #1;
      if (h0) begin
        k0++;
        if (k0 == 2) req_valid[0] = 1'b0; else set_req(0, 8'd90, 8'd9);
      end
      if (h1) begin
        k1++;
        if (k1 == 2) req_valid[1] = 1'b0; else set_req(1, 8'd200, 8'd8);
      end
      guard++;
    end
    if (guard >= 300) chk("tie_timeout", 0, 1);
    wait_idle(100);

    // Single request: 100/5 = 20, response 10 cycles after acceptance.
    push(1'b0, 8'd20, 1'b0, 1'b0, 8'd10);
    send(0, 8'd100, 8'd5);
    wait_idle(100);

    // Divide by zero on requester 1: no launch, response next cycle.
    n0 = n_start;
    push(1'b1, 8'hFF, 1'b1, 1'b0, 8'd1);
    send(1, 8'd37, 8'd0);
    wait_idle(50);
    chk("dz_no_start", n_start, n0);

    // Hung divider, then a normal request 45/9 = 5.
    hang = 1'b1;
    push(1'b0, 8'd0, 1'b0, 1'b1, 8'd66);
    send(0, 8'd12, 8'd3);
    wait_idle(300);
    hang = 1'b0;
    push(1'b1, 8'd5, 1'b0, 1'b0, 8'd10);
    send(1, 8'd45, 8'd9);
    wait_idle(100);

    // Backpressure: 100/4 = 25 held for 20 cycles while req1 (9/3 = 3) waits.
    rsp_ready = 2'b10;
    push(1'b0, 8'd25, 1'b0, 1'b0, 8'd10);
    push(1'b1, 8'd3, 1'b0, 1'b0, 8'd10);
    send(0, 8'd100, 8'd4);
    set_req(1, 8'd9, 8'd3);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    if (!seen) chk("bp_rsp_timeout", 0, 1);
    repeat (19) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req1_accept", {30'd0, req_ready}, 2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle(100);

    // Reset in WAIT, then a stray done: nothing may come out.
    hang = 1'b1;
    send(0, 8'd50, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_state", {30'd0, dbg_state}, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    reset      = 1'b0;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("stray_rsp_valid", {30'd0, rsp_valid}, 0);
      chk("stray_busy", {31'd0, busy}, 0);
    end
    chk("post_reset_last", {31'd0, dbg_last}, 1);
    hang = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
